// File: rtl/counter_if.sv
// counter_if: bundles the per-cycle control inputs (ce, sclr) and the
// results (cnt, ceo) of one counter instance so a parent can hand a
// single port to the counter and keep clock/reset as plain wires.
interface counter_if #(
  parameter int W = 8
);

  logic         ce;
  logic         sclr;
  logic [W-1:0] cnt;
  logic         ceo;

  // The parent that owns the timing decisions drives ce/sclr and watches results.
  modport master (
    output ce,
    output sclr,
    input  cnt,
    input  ceo
  );

  // The counter itself consumes the controls and produces count and strobe.
  modport slave (
    input  ce,
    input  sclr,
    output cnt,
    output ceo
  );

endinterface

// File: rtl/counter.sv
// counter: generic up-counter used as the timing primitive of the Morse
// capture/generation blocks (pulse-length measurement in clock ticks).
// Counts 0..MODULO-1, then either wraps to 0 or holds at MODULO-1.
// sclr loads a constant but only on enabled cycles, so an unconditional
// clear must be ORed into ce by the caller. ceo is a combinational
// terminal-count strobe meant to be sampled on the next edge, which lets
// several counters be cascaded (ceo of one stage feeding ce of the next).
module counter #(
  parameter int          W        = 8,
  parameter logic [31:0] SCLR_VAL = 32'd0,
  parameter logic [32:0] MODULO   = 33'd1 << W,
  parameter bit          SATURATE = 1'b0
) (
  input logic       clk,
  input logic       aclr_n,
  counter_if.slave  bus
);

  // Last legal count; MODULO may be up to 2**W, so it is formed in 33 bits
  // and then cut down to the counter width.
  localparam logic [W-1:0] TERM = W'(MODULO - 33'd1);

  // Value placed in the counter by sclr; it is allowed to lie above TERM and
  // is then cleaned up by the wrap/hold rule on the next enabled edge.
  localparam logic [W-1:0] LOAD = SCLR_VAL[W-1:0];

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_term;

  // ">=" rather than "==" so an out-of-range load also wraps or holds.
  assign at_term = (cnt_q >= TERM);

  // Next-count selection: enable gates everything, load beats terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.ce) begin
      if (bus.sclr) begin
        cnt_d = LOAD;
      end else if (at_term) begin
        cnt_d = SATURATE ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  // Count register; aclr_n clears it immediately regardless of the clock.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal-count strobe: only on an enabled, non-loading cycle sitting
  // exactly at TERM, and forced low while reset is asserted.
  always_comb begin
    bus.ceo = aclr_n & bus.ce & ~bus.sclr & (cnt_q == TERM);
  end

  assign bus.cnt = cnt_q;

endmodule

// File: tb/tb_counter.sv
// tb_counter: five counter configurations share one clock and reset. A
// fixed vector table covers the modulo-10 wrap/saturate/out-of-range-load
// cases, hand-written sequences cover reset, free-run wrap, enable gating
// and load, and a random phase compares all instances with a rule-based
// reference model.
module tb_counter;

  logic clk = 1'b0;
  logic aclrN;

  always #5 clk = ~clk;

  // idx 0: W=8 default; idx 1: W=4 MOD16; idx 2: W=16 MOD600 SCLR_VAL=1;
  // idx 3: W=4 MOD10 wrap SCLR_VAL=12; idx 4: W=4 MOD10 saturate SCLR_VAL=12
  counter_if #(.W(8))  if8   ();
  counter_if #(.W(4))  if4   ();
  counter_if #(.W(16)) if16  ();
  counter_if #(.W(4))  if10w ();
  counter_if #(.W(4))  if10s ();

  counter #(.W(8)) u8 (.clk(clk), .aclr_n(aclrN), .bus(if8));
  counter #(.W(4), .MODULO(33'd16), .SATURATE(1'b0)) u4 (.clk(clk), .aclr_n(aclrN), .bus(if4));
  counter #(.W(16), .SCLR_VAL(32'd1), .MODULO(33'd600)) u16 (.clk(clk), .aclr_n(aclrN), .bus(if16));
  counter #(.W(4), .SCLR_VAL(32'd12), .MODULO(33'd10), .SATURATE(1'b0)) u10w (.clk(clk), .aclr_n(aclrN), .bus(if10w));
  counter #(.W(4), .SCLR_VAL(32'd12), .MODULO(33'd10), .SATURATE(1'b1)) u10s (.clk(clk), .aclr_n(aclrN), .bus(if10s));

  typedef struct {
    bit ce;
    bit sclr;
    bit ceoW;
    bit ceoS;
    int expW;
    int expS;
  } vec_t;

  vec_t   vecs[$];
  int     checks = 0;
  int     errors = 0;
  longint mdl[5];
  bit     ceV[5];
  bit     sclrV[5];

  // Configuration of each instance, as the reference model sees it.
  function automatic int cfgW(int idx);
    case (idx)
      0: return 8;
      2: return 16;
      default: return 4;
    endcase
  endfunction

  function automatic longint cfgMod(int idx);
    case (idx)
      0: return 256;
      1: return 16;
      2: return 600;
      default: return 10;
    endcase
  endfunction

  function automatic bit cfgSat(int idx);
    return (idx == 4);
  endfunction

  function automatic longint cfgSv(int idx);
    case (idx)
      2: return 1;
      3, 4: return 12;
      default: return 0;
    endcase
  endfunction

  // Reference model: the priority rules written as plain arithmetic.
  function automatic longint modelNext(int idx, longint c, bit ce, bit sclr);
    longint span;
    span = longint'(1) << cfgW(idx);
    if (!ce) return c;
    if (sclr) return cfgSv(idx) % span;
    if (c >= cfgMod(idx) - 1) return cfgSat(idx) ? c : 0;
    return (c + 1) % span;
  endfunction

  function automatic bit modelCeo(int idx, longint c, bit ce, bit sclr, bit rstN);
    return rstN && ce && !sclr && (c == cfgMod(idx) - 1);
  endfunction

  function automatic logic [63:0] getCnt(int idx);
    case (idx)
      0: return 64'(if8.cnt);
      1: return 64'(if4.cnt);
      2: return 64'(if16.cnt);
      3: return 64'(if10w.cnt);
      default: return 64'(if10s.cnt);
    endcase
  endfunction

  function automatic logic [63:0] getCeo(int idx);
    case (idx)
      0: return 64'(if8.ceo);
      1: return 64'(if4.ceo);
      2: return 64'(if16.ceo);
      3: return 64'(if10w.ceo);
      default: return 64'(if10s.ceo);
    endcase
  endfunction

  task automatic setIn(int idx, bit c, bit s);
    case (idx)
      0: begin if8.ce = c;   if8.sclr = s;   end
      1: begin if4.ce = c;   if4.sclr = s;   end
      2: begin if16.ce = c;  if16.sclr = s;  end
      3: begin if10w.ce = c; if10w.sclr = s; end
      default: begin if10s.ce = c; if10s.sclr = s; end
    endcase
  endtask

  task automatic checkOutput(string name, logic [63:0] act, longint exp);
    checks++;
    if (act !== 64'(exp)) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock of stimulus for every instance: drive, check ceo before the
  // edge, then check the count after the edge against the model.
  task automatic applyStimulus(string tag);
    for (int i = 0; i < 5; i++) setIn(i, ceV[i], sclrV[i]);
    #1;
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("%s ceo[%0d]", tag, i), getCeo(i),
                  longint'(modelCeo(i, mdl[i], ceV[i], sclrV[i], aclrN)));
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      mdl[i] = modelNext(i, mdl[i], ceV[i], sclrV[i]);
      checkOutput($sformatf("%s cnt[%0d]", tag, i), getCnt(i), mdl[i]);
    end
  endtask

  task automatic clearInputs();
    for (int i = 0; i < 5; i++) begin
      ceV[i] = 1'b0;
      sclrV[i] = 1'b0;
      setIn(i, 1'b0, 1'b0);
    end
  endtask

  // Full reset across two edges; leaves time at edge+3 with reset released.
  task automatic doReset();
    clearInputs();
    aclrN = 1'b0;
    for (int i = 0; i < 5; i++) mdl[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("reset cnt[%0d]", i), getCnt(i), 0);
      checkOutput($sformatf("reset ceo[%0d]", i), getCeo(i), 0);
    end
    #2 aclrN = 1'b1;
  endtask

  // Reset pulse between edges with the current inputs still applied.
  task automatic midReset();
    #1 aclrN = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      mdl[i] = 0;
      checkOutput($sformatf("midreset cnt[%0d]", i), getCnt(i), 0);
      checkOutput($sformatf("midreset ceo[%0d]", i), getCeo(i), 0);
    end
    @(posedge clk);
    #1 aclrN = 1'b1;
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: timeout reached, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Modulo-10 vector table: 12 enabled edges, load 12 at terminal count,
    // out-of-range cleanup, disabled load, then one more enabled edge.
    for (int i = 1; i <= 12; i++)
      vecs.push_back('{ce: 1'b1, sclr: 1'b0, ceoW: (i == 10), ceoS: (i >= 10),
                       expW: i % 10, expS: (i < 9) ? i : 9});
    vecs.push_back('{ce: 1'b1, sclr: 1'b1, ceoW: 1'b0, ceoS: 1'b0, expW: 12, expS: 12});
    vecs.push_back('{ce: 1'b1, sclr: 1'b0, ceoW: 1'b0, ceoS: 1'b0, expW: 0,  expS: 12});
    vecs.push_back('{ce: 1'b0, sclr: 1'b1, ceoW: 1'b0, ceoS: 1'b0, expW: 0,  expS: 12});
    vecs.push_back('{ce: 1'b1, sclr: 1'b0, ceoW: 1'b0, ceoS: 1'b0, expW: 1,  expS: 12});

    aclrN = 1'b0;
    clearInputs();
    #2;

    // Reset: count to 0x37, asynchronous clear, hold, resume from 0.
    doReset();
    ceV[0] = 1'b1;
    repeat (55) applyStimulus("run8");
    checkOutput("cnt8 reaches 0x37", getCnt(0), 'h37);
    #2 aclrN = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) mdl[i] = 0;
    checkOutput("async clear cnt8", getCnt(0), 0);
    checkOutput("ceo8 gated by reset", getCeo(0), 0);
    @(posedge clk);
    #1;
    checkOutput("cnt8 held in reset", getCnt(0), 0);
    #2 aclrN = 1'b1;
    applyStimulus("resume8");
    checkOutput("cnt8 resume 1", getCnt(0), 1);
    applyStimulus("resume8");
    checkOutput("cnt8 resume 2", getCnt(0), 2);

    // Free run with binary wrap at 16.
    doReset();
    ceV[1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus("wrap16");
      checkOutput($sformatf("wrap16 step %0d", k), getCnt(1), k % 16);
    end

    // Enable gating, and sclr ignored while ce is low.
    doReset();
    for (int k = 0; k < 8; k++) begin
      ceV[0] = (k % 2 == 0);
      applyStimulus("gate8");
    end
    checkOutput("gated count", getCnt(0), 4);
    ceV[0] = 1'b0;
    sclrV[0] = 1'b1;
    applyStimulus("gate8");
    checkOutput("sclr without ce", getCnt(0), 4);
    sclrV[0] = 1'b0;

    // Synchronous load on the 16-bit instance, and load at terminal count.
    doReset();
    ceV[2] = 1'b1;
    repeat (500) applyStimulus("run16");
    checkOutput("cnt16 at 500", getCnt(2), 500);
    sclrV[2] = 1'b1;
    applyStimulus("load16");
    checkOutput("load16 value", getCnt(2), 1);
    sclrV[2] = 1'b0;
    applyStimulus("load16");
    checkOutput("after load16", getCnt(2), 2);
    repeat (597) applyStimulus("run16");
    checkOutput("cnt16 at 599", getCnt(2), 599);
    setIn(2, 1'b1, 1'b0);
    #1;
    checkOutput("ceo16 at terminal", getCeo(2), 1);
    setIn(2, 1'b1, 1'b1);
    #1;
    checkOutput("ceo16 sclr at terminal", getCeo(2), 0);
    sclrV[2] = 1'b1;
    applyStimulus("tcload16");
    checkOutput("sclr wins at terminal", getCnt(2), 1);
    sclrV[2] = 1'b0;

    // Modulo-10 table on the wrap and saturate instances together.
    doReset();
    foreach (vecs[n]) begin
      ceV[3] = vecs[n].ce;  sclrV[3] = vecs[n].sclr;
      ceV[4] = vecs[n].ce;  sclrV[4] = vecs[n].sclr;
      setIn(3, vecs[n].ce, vecs[n].sclr);
      setIn(4, vecs[n].ce, vecs[n].sclr);
      #1;
      checkOutput($sformatf("vec%0d ceoW", n), getCeo(3), longint'(vecs[n].ceoW));
      checkOutput($sformatf("vec%0d ceoS", n), getCeo(4), longint'(vecs[n].ceoS));
      applyStimulus("vec");
      checkOutput($sformatf("vec%0d cntW", n), getCnt(3), vecs[n].expW);
      checkOutput($sformatf("vec%0d cntS", n), getCnt(4), vecs[n].expS);
    end

    // Random phase against the reference model, with occasional resets.
    doReset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 5; i++) begin
        ceV[i] = ($urandom_range(0, 3) != 0);
        sclrV[i] = ($urandom_range(0, 15) == 0);
      end
      applyStimulus("rand");
      if ($urandom_range(0, 49) == 0) midReset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
